// File: rtl/dac_frame_sequencer.sv
// dac_frame_sequencer: turns one stereo sample pair per tick into two 24-bit
// DAC command words, spacing the send strobes SEND_GAP clocks apart so each
// SPI transaction (including its CS-high pulse) finishes before the next one.
// One pair can wait in a pending register while a frame is in flight.
//
// state  | meaning
// IDLE   | no frame in flight, waiting for a pending pair
// SEND_A | issue channel A word and strobe, load gap counter
// WAIT_A | count down the gap after the A strobe
// SEND_B | issue channel B word and strobe, load gap counter
// WAIT_B | count down the gap after the B strobe; chain straight into the
//        | next frame if a pair is pending so B-to-A spacing equals SEND_GAP
module dac_frame_sequencer #(
  parameter logic [15:0] SEND_GAP  = 16'd600,
  parameter logic [7:0]  CMD_A     = 8'h10,
  parameter logic [7:0]  CMD_B     = 8'h24,
  parameter logic        SIGNED_IN = 1'b1
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic [15:0] sample_a,
  input  logic [15:0] sample_b,
  input  logic        sample_valid,
  input  logic        clear_overrun,
  output logic [23:0] dac_data,
  output logic        dac_send,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B} state_t;

  state_t      state_q, state_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] pend_a_q, pend_b_q;
  logic [15:0] work_a_q, work_b_q;
  logic        pend_full_q, pend_full_d;
  logic        take;
  logic        send_d;
  logic [23:0] data_d;
  logic        ovr_set;
  logic [15:0] conv_a, conv_b;

  // Offset-binary conversion happens at capture so the pending pair is DAC-ready.
  assign conv_a = SIGNED_IN ? {~sample_a[15], sample_a[14:0]} : sample_a;
  assign conv_b = SIGNED_IN ? {~sample_b[15], sample_b[14:0]} : sample_b;

  // A newer pair overwrites a still-pending one unless that one leaves this edge.
  assign pend_full_d = sample_valid | (pend_full_q & ~take);
  assign ovr_set     = sample_valid & pend_full_q & ~take;

  // Next-state, gap counter and next registered outputs.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    take    = 1'b0;
    send_d  = 1'b0;
    data_d  = dac_data;
    case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          take    = 1'b1;
          state_d = SEND_A;
        end
      end
      SEND_A: begin
        send_d  = 1'b1;
        data_d  = {CMD_A, work_a_q};
        gap_d   = SEND_GAP - 16'd1;
        state_d = WAIT_A;
      end
      WAIT_A: begin
        if (gap_q <= 16'd1) begin
          gap_d   = 16'd0;
          state_d = SEND_B;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      SEND_B: begin
        send_d  = 1'b1;
        data_d  = {CMD_B, work_b_q};
        gap_d   = SEND_GAP - 16'd1;
        state_d = WAIT_B;
      end
      WAIT_B: begin
        if (gap_q <= 16'd1) begin
          gap_d = 16'd0;
          if (pend_full_q) begin
            take    = 1'b1;
            state_d = SEND_A;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, sample buffers and registered outputs.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q     <= IDLE;
      gap_q       <= 16'd0;
      pend_a_q    <= 16'd0;
      pend_b_q    <= 16'd0;
      work_a_q    <= 16'd0;
      work_b_q    <= 16'd0;
      pend_full_q <= 1'b0;
      dac_data    <= 24'h0;
      dac_send    <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      pend_full_q <= pend_full_d;
      dac_data    <= data_d;
      dac_send    <= send_d;
      busy        <= (state_d != IDLE) | pend_full_d;
      if (take) begin
        work_a_q <= pend_a_q;
        work_b_q <= pend_b_q;
      end
      if (sample_valid) begin
        pend_a_q <= conv_a;
        pend_b_q <= conv_b;
      end
      if (ovr_set)            overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Bench for dac_frame_sequencer: a cycle table for the basic frame, directed
// sequences for queuing/overrun/reset corners, and random traffic checked
// against a timestamp-based reference model. Two instances share stimulus:
// one signed-input, one unsigned-input, both with an 8-clock gap.
module tb_dac_frame_sequencer;

  localparam int G = 8;
  localparam logic [7:0] CA = 8'h10;
  localparam logic [7:0] CB = 8'h24;

  logic clock_in = 1'b0;
  logic reset = 1'b0;
  logic [15:0] sample_a = '0, sample_b = '0;
  logic sample_valid = 1'b0, clear_overrun = 1'b0;
  logic [23:0] d_s, d_u;
  logic s_s, s_u, b_s, b_u, o_s, o_u;

  int checks = 0;
  int errors = 0;

  always #5 clock_in = ~clock_in;

  dac_frame_sequencer #(.SEND_GAP(16'd8), .CMD_A(CA), .CMD_B(CB), .SIGNED_IN(1'b1)) u_s (
    .clock_in(clock_in), .reset(reset), .sample_a(sample_a), .sample_b(sample_b),
    .sample_valid(sample_valid), .clear_overrun(clear_overrun),
    .dac_data(d_s), .dac_send(s_s), .busy(b_s), .overrun(o_s));

  dac_frame_sequencer #(.SEND_GAP(16'd8), .CMD_A(CA), .CMD_B(CB), .SIGNED_IN(1'b0)) u_u (
    .clock_in(clock_in), .reset(reset), .sample_a(sample_a), .sample_b(sample_b),
    .sample_valid(sample_valid), .clear_overrun(clear_overrun),
    .dac_data(d_u), .dac_send(s_u), .busy(b_u), .overrun(o_u));

  // Reference model: a pair taken at edge T strobes A at T+1 and B at T+1+G;
  // the sequencer is free to take the next pair at T+2G.
  longint t = 0;
  bit pv = 0;
  logic [15:0] pa = '0, pb = '0, wa = '0, wb = '0;
  longint take_t = -1000, free_e = 0, act_until = 0;
  bit m_ovr = 0, e_send = 0, e_busy = 0;
  logic [23:0] e_ds = '0, e_du = '0;

  typedef struct { longint t; logic [23:0] ds; logic [23:0] du; } ev_t;
  ev_t log_q[$];

  function automatic logic [15:0] sconv(input logic [15:0] s);
    return s ^ 16'h8000;
  endfunction

  task automatic model_step(input bit rst, input bit sv, input logic [15:0] a, b, input bit clr);
    bit tk, set;
    t++;
    if (rst) begin
      pv = 0; take_t = -1000; free_e = 0; act_until = 0; m_ovr = 0;
      e_send = 0; e_ds = '0; e_du = '0; e_busy = 0;
      return;
    end
    tk = pv && (t >= free_e);
    if (tk) begin
      take_t = t; wa = pa; wb = pb; free_e = t + 2*G; act_until = t + 2*G; pv = 0;
    end
    set = sv && pv;
    if (sv) begin pa = a; pb = b; pv = 1; end
    if (set) m_ovr = 1;
    else if (clr) m_ovr = 0;
    if (t == take_t + 1) begin
      e_send = 1; e_ds = {CA, sconv(wa)}; e_du = {CA, wa};
    end else if (t == take_t + 1 + G) begin
      e_send = 1; e_ds = {CB, sconv(wb)}; e_du = {CB, wb};
    end else begin
      e_send = 0;
    end
    e_busy = (t < act_until) || pv;
  endtask

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", nm, t, act, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit sv, input logic [15:0] a, b, input bit clr);
    @(negedge clock_in);
    reset = rst; sample_valid = sv; sample_a = a; sample_b = b; clear_overrun = clr;
    @(posedge clock_in);
    model_step(rst, sv, a, b, clr);
    #1;
    chk("send_s", {23'd0, s_s}, {23'd0, e_send});
    chk("data_s", d_s, e_ds);
    chk("busy_s", {23'd0, b_s}, {23'd0, e_busy});
    chk("ovr_s", {23'd0, o_s}, {23'd0, m_ovr});
    chk("send_u", {23'd0, s_u}, {23'd0, e_send});
    chk("data_u", d_u, e_du);
    chk("busy_u", {23'd0, b_u}, {23'd0, e_busy});
    chk("ovr_u", {23'd0, o_u}, {23'd0, m_ovr});
    if (s_s) log_q.push_back('{t, d_s, d_u});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 16'h0, 0);
  endtask

  typedef struct {
    bit rst; bit sv; logic [15:0] a; logic [15:0] b; bit clr;
    bit send; logic [23:0] data; bit busy; bit ovr;
  } vec_t;
  vec_t tbl[19];

  function automatic vec_t mk(input bit rst, sv, input logic [15:0] a, b,
                              input bit send, input logic [23:0] data, input bit busy);
    vec_t v;
    v.rst = rst; v.sv = sv; v.a = a; v.b = b; v.clr = 0;
    v.send = send; v.data = data; v.busy = busy; v.ovr = 0;
    return v;
  endfunction

  initial begin
    int idx_b;
    logic [15:0] ra, rb;

    // Basic frame, signed instance: a=0000,b=8000 -> 108000 then 240000.
    tbl[0] = mk(1, 0, 16'h0, 16'h0, 0, 24'h0, 0);
    tbl[1] = mk(0, 1, 16'h0000, 16'h8000, 0, 24'h0, 1);
    tbl[2] = mk(0, 0, 16'h0, 16'h0, 0, 24'h0, 1);
    tbl[3] = mk(0, 0, 16'h0, 16'h0, 1, 24'h108000, 1);
    for (int i = 4; i <= 10; i++) tbl[i] = mk(0, 0, 16'h0, 16'h0, 0, 24'h108000, 1);
    tbl[11] = mk(0, 0, 16'h0, 16'h0, 1, 24'h240000, 1);
    for (int i = 12; i <= 17; i++) tbl[i] = mk(0, 0, 16'h0, 16'h0, 0, 24'h240000, 1);
    tbl[18] = mk(0, 0, 16'h0, 16'h0, 0, 24'h240000, 0);

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].rst, tbl[i].sv, tbl[i].a, tbl[i].b, tbl[i].clr);
      chk($sformatf("tbl%0d_send", i), {23'd0, s_s}, {23'd0, tbl[i].send});
      chk($sformatf("tbl%0d_data", i), d_s, tbl[i].data);
      chk($sformatf("tbl%0d_busy", i), {23'd0, b_s}, {23'd0, tbl[i].busy});
      chk($sformatf("tbl%0d_ovr", i), {23'd0, o_s}, {23'd0, tbl[i].ovr});
    end
    idle(3);

    // Unsigned words, exactly two strobes per tick.
    log_q.delete();
    cyc(0, 1, 16'h1234, 16'hABCD, 0);
    idle(20);
    chk("unsigned_strobes", 24'(log_q.size()), 24'd2);
    if (log_q.size() >= 2) begin
      chk("unsigned_word_a", log_q[0].du, 24'h101234);
      chk("unsigned_word_b", log_q[1].du, 24'h24ABCD);
    end

    // Second tick during WAIT_A: next A exactly G clocks after B, no overrun.
    log_q.delete();
    cyc(0, 1, 16'h1111, 16'h2222, 0);
    idle(4);
    cyc(0, 1, 16'h3333, 16'h4444, 0);
    idle(30);
    chk("queued_strobes", 24'(log_q.size()), 24'd4);
    if (log_q.size() >= 3)
      chk("b_to_a_gap", 24'(log_q[2].t - log_q[1].t), 24'(G));
    chk("queued_no_ovr", {23'd0, o_s}, 24'd0);

    // Three ticks in one frame: overrun, middle pair dropped.
    log_q.delete();
    cyc(0, 1, 16'h0101, 16'h0202, 0);
    idle(3);
    cyc(0, 1, 16'h0303, 16'h0404, 0);
    idle(1);
    cyc(0, 1, 16'h0505, 16'h0606, 0);
    chk("three_tick_ovr", {23'd0, o_u}, 24'd1);
    idle(35);
    chk("three_tick_strobes", 24'(log_q.size()), 24'd4);
    if (log_q.size() >= 3) begin
      chk("three_tick_first", log_q[0].du, 24'h100101);
      chk("three_tick_third", log_q[2].du, 24'h100505);
    end

    // clear_overrun loses to a simultaneous set, then clears on its own.
    cyc(0, 1, 16'h0707, 16'h0808, 0);
    idle(3);
    cyc(0, 1, 16'h0909, 16'h0A0A, 0);
    cyc(0, 1, 16'h0B0B, 16'h0C0C, 1);
    chk("clr_vs_set", {23'd0, o_s}, 24'd1);
    cyc(0, 0, 16'h0, 16'h0, 1);
    chk("clr_alone", {23'd0, o_s}, 24'd0);
    idle(40);

    // Reset during WAIT_A abandons the frame; next tick restarts from A.
    cyc(0, 1, 16'h5A5A, 16'hA5A5, 0);
    idle(4);
    log_q.delete();
    cyc(1, 0, 16'h0, 16'h0, 0);
    chk("rst_send", {23'd0, s_s}, 24'd0);
    chk("rst_data", d_s, 24'h0);
    chk("rst_busy", {23'd0, b_s}, 24'd0);
    idle(20);
    chk("rst_no_b", 24'(log_q.size()), 24'd0);
    cyc(0, 1, 16'h7FFF, 16'h8001, 0);
    idle(2);
    chk("restart_send", {23'd0, s_s}, 24'd1);
    chk("restart_word", d_s, 24'h10FFFF);
    idle(20);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 5) == 0), ra, rb,
          ($urandom_range(0, 19) == 0));
    end

    // Strobes never on two consecutive cycles anywhere in the random run.
    idx_b = 0;
    for (int i = 1; i < log_q.size(); i++)
      if (log_q[i].t - log_q[i-1].t < 2) idx_b++;
    chk("no_back_to_back", 24'(idx_b), 24'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
